// File: rtl/regfile_pkg.sv
// Shared register-file constants for the processing-element datapath.
// Items: RF_AW (address width), RF_DW (data width), RF_NUM_REGS, RF_ZERO_REG.
package regfile_pkg;
  localparam int unsigned RF_AW       = 5;
  localparam int unsigned RF_DW       = 32;
  localparam int unsigned RF_NUM_REGS = 32;
  localparam logic [RF_AW-1:0] RF_ZERO_REG = 5'd0;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the NREQ writeback sources and the arbiter.
// Signals: req_valid/req_ready/req_rd/req_wd (requester handshake),
//          rf_we/rf_rd/rf_wd (registered register-file write port),
//          grant_id (last accepted requester).
// Optional (WBARB_SCOREBOARD_EN): rsv_valid/rsv_rd (issue reservation),
//          busy (per-register pending-write bitmap).
// Modports: slave = arbiter side, master = sources / register-file side.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = RF_AW,
  parameter int unsigned DW   = RF_DW
);
  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned NR = 2 ** AW;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_wd;
  logic               rf_we;
  logic [AW-1:0]      rf_rd;
  logic [DW-1:0]      rf_wd;
  logic [IW-1:0]      grant_id;
`ifdef WBARB_SCOREBOARD_EN
  logic               rsv_valid;
  logic [AW-1:0]      rsv_rd;
  logic [NR-1:0]      busy;
`endif

  modport slave (
    input  req_valid, req_rd, req_wd,
    output req_ready, rf_we, rf_rd, rf_wd, grant_id
`ifdef WBARB_SCOREBOARD_EN
    , input rsv_valid, rsv_rd
    , output busy
`endif
  );

  modport master (
    output req_valid, req_rd, req_wd,
    input  req_ready, rf_we, rf_rd, rf_wd, grant_id
`ifdef WBARB_SCOREBOARD_EN
    , output rsv_valid, rsv_rd
    , input busy
`endif
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter.
// Ports: req_i (requests), ptr_i (last winner; search starts at ptr_i+1 mod N),
//        gnt_o (one-hot grant), idx_o (winner index), any_o (some request granted).
module rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  // First requester found scanning upward from ptr_i+1 with wrap wins.
  always_comb begin
    int unsigned j;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = (32'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
    any_o = found;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among
// NREQ writeback sources, with a registered write stage.
// Ports: clk, rst_n (async active-low), bus (regfile_wb_arbiter_if.slave).
// Build option: WBARB_SCOREBOARD_EN adds the reservation scoreboard
// (rsv_valid/rsv_rd in, busy bitmap out).
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = RF_AW,
  parameter int unsigned DW   = RF_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned NR = 2 ** AW;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   win_idx;
  logic            xfer;
  logic [AW-1:0]   win_rd;
  logic [DW-1:0]   win_wd;

  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_rd_q, rf_rd_d;
  logic [DW-1:0]   rf_wd_q, rf_wd_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [IW-1:0]   ptr_q, ptr_d;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (xfer)
  );

  // Grant only ever follows a valid, so any grant is a transfer.
  assign bus.req_ready = gnt;

  // One-hot mux of the winner's payload.
  always_comb begin
    win_rd = '0;
    win_wd = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_rd = bus.req_rd[i*AW +: AW];
        win_wd = bus.req_wd[i*DW +: DW];
      end
    end
  end

  // Write stage next state; writes to the zero register are swallowed.
  always_comb begin
    rf_we_d = 1'b0;
    rf_rd_d = rf_rd_q;
    rf_wd_d = rf_wd_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      rf_we_d = (win_rd != AW'(RF_ZERO_REG));
      rf_rd_d = win_rd;
      rf_wd_d = win_wd;
      gid_d   = win_idx;
      ptr_d   = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
      rf_wd_q <= '0;
      gid_q   <= '0;
      ptr_q   <= IW'(NREQ - 1);
    end else begin
      rf_we_q <= rf_we_d;
      rf_rd_q <= rf_rd_d;
      rf_wd_q <= rf_wd_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_rd    = rf_rd_q;
  assign bus.rf_wd    = rf_wd_q;
  assign bus.grant_id = gid_q;

`ifdef WBARB_SCOREBOARD_EN
  logic [NR-1:0] busy_q, busy_d;

  // Clear on accepted write, then set on reservation so set wins.
  always_comb begin
    busy_d = busy_q;
    if (xfer && (win_rd != AW'(RF_ZERO_REG))) busy_d[win_rd] = 1'b0;
    if (bus.rsv_valid && (bus.rsv_rd != AW'(RF_ZERO_REG))) busy_d[bus.rsv_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign bus.busy = busy_q;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;
  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = RF_AW;
  localparam int unsigned DW   = RF_DW;
  localparam int unsigned NR   = 2 ** AW;

  logic clk = 1'b0;
  logic rst_n;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Requester-side stimulus state
  logic          v  [NREQ];
  logic [AW-1:0] rd [NREQ];
  logic [DW-1:0] wd [NREQ];
  logic          rv;
  logic [AW-1:0] rrd;

  // Reference model state
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_wd;
  int            m_gid;
  logic [NR-1:0] m_busy;
  int            last_win;
  logic [DW-1:0] held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]        = v[i];
      bus.req_rd[i*AW +: AW]  = rd[i];
      bus.req_wd[i*DW +: DW]  = wd[i];
    end
`ifdef WBARB_SCOREBOARD_EN
    bus.rsv_valid = rv;
    bus.rsv_rd    = rrd;
`endif
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b0; rd[i] = '0; wd[i] = '0;
    end
    rv = 1'b0; rrd = '0;
  endtask

  // Winner: first valid requester after the last one granted, wrapping.
  function automatic int winner();
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = NREQ - 1; m_we = 1'b0; m_rd = '0; m_wd = '0; m_gid = 0; m_busy = '0;
  endtask

  task automatic check_regs(input string pfx);
    chk({pfx, "_rf_we"}, 64'(bus.rf_we), 64'(m_we));
    chk({pfx, "_rf_rd"}, 64'(bus.rf_rd), 64'(m_rd));
    chk({pfx, "_rf_wd"}, 64'(bus.rf_wd), 64'(m_wd));
    chk({pfx, "_gid"},   64'(bus.grant_id), 64'(m_gid));
`ifdef WBARB_SCOREBOARD_EN
    chk({pfx, "_busy"},  64'(bus.busy), 64'(m_busy));
`endif
  endtask

  // One clock: entered and left at negedge with inputs already set.
  task automatic cycle(input string pfx);
    int w;
    logic [NREQ-1:0] er;
    drive();
    #1;
    w  = winner();
    er = (w >= 0) ? NREQ'(1 << w) : '0;
    chk({pfx, "_ready"}, 64'(bus.req_ready), 64'(er));
    last_win = w;
    @(posedge clk);
    if (w >= 0) begin
      m_we  = (rd[w] != '0);
      m_rd  = rd[w];
      m_wd  = wd[w];
      m_gid = w;
      m_ptr = w;
`ifdef WBARB_SCOREBOARD_EN
      if (rd[w] != '0) m_busy[rd[w]] = 1'b0;
`endif
    end else begin
      m_we = 1'b0;
    end
`ifdef WBARB_SCOREBOARD_EN
    if (rv && rrd != '0) m_busy[rrd] = 1'b1;
`endif
    #1;
    check_regs(pfx);
    @(negedge clk);
  endtask

  task automatic all_valid();
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b1; rd[i] = AW'(i + 1); wd[i] = $urandom;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    drive();
    model_reset();
    #12;
    check_regs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Contention from reset: 0,1,2,0,1,2 with a write every cycle
    all_valid();
    for (int c = 0; c < 6; c++) begin
      cycle("t3");
      chk("t3_seq", 64'(bus.grant_id), 64'(c % NREQ));
      chk("t3_we",  64'(bus.rf_we), 64'(1));
    end

    // Reset while a write is registered: outputs drop at once
`ifdef WBARB_SCOREBOARD_EN
    rv = 1'b1; rrd = AW'(5);
    cycle("t1pre");
    rv = 1'b0;
`endif
    chk("t1_we_before", 64'(bus.rf_we), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("t1_we_async",  64'(bus.rf_we), 64'(0));
    chk("t1_gid_async", 64'(bus.grant_id), 64'(0));
`ifdef WBARB_SCOREBOARD_EN
    chk("t1_busy_async", 64'(bus.busy), 64'(0));
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    all_valid();
    cycle("t1");
    chk("t1_first", 64'(bus.grant_id), 64'(0));
    clear_inputs();
    cycle("idle");

    // Single source
    v[1] = 1'b1; rd[1] = AW'(7); wd[1] = 32'hDEADBEEF;
    cycle("t2");
    chk("t2_rd",  64'(bus.rf_rd), 64'(7));
    chk("t2_wd",  64'(bus.rf_wd), 64'(32'hDEADBEEF));
    chk("t2_gid", 64'(bus.grant_id), 64'(1));
    v[1] = 1'b0;

    // Zero register: accepted, no write, pointer still moves
    v[2] = 1'b1; rd[2] = '0; wd[2] = 32'h1234_5678;
    cycle("t4");
    chk("t4_we", 64'(bus.rf_we), 64'(0));
    all_valid();
    cycle("t4b");
    chk("t4_next", 64'(bus.grant_id), 64'(0));

    // Hold rule: req0 waits two cycles behind req1, req2
    held = 32'hCAFE_0001;
    v[0] = 1'b1; rd[0] = AW'(11); wd[0] = held;
    cycle("t6a");
    chk("t6_g1", 64'(bus.grant_id), 64'(1));
    v[1] = 1'b0;
    cycle("t6b");
    chk("t6_g2", 64'(bus.grant_id), 64'(2));
    v[2] = 1'b0;
    cycle("t6c");
    chk("t6_g0", 64'(bus.grant_id), 64'(0));
    chk("t6_wd", 64'(bus.rf_wd), 64'(held));
    clear_inputs();

`ifdef WBARB_SCOREBOARD_EN
    rv = 1'b1; rrd = AW'(9);
    cycle("t5a");
    chk("t5_set", 64'(bus.busy[9]), 64'(1));
    v[0] = 1'b1; rd[0] = AW'(9); wd[0] = $urandom;
    cycle("t5b");
    chk("t5_setwins", 64'(bus.busy[9]), 64'(1));
    rv = 1'b0;
    wd[0] = $urandom;
    cycle("t5c");
    chk("t5_clear", 64'(bus.busy[9]), 64'(0));
    clear_inputs();
`endif

    // Randomized traffic obeying the hold rule, with occasional drops
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i]) begin
          if ($urandom_range(2) == 0) begin
            v[i] = 1'b1; rd[i] = AW'($urandom); wd[i] = $urandom;
          end
        end else if ($urandom_range(7) == 0) begin
          v[i] = 1'b0;
        end
      end
      rv  = ($urandom_range(3) == 0);
      rrd = AW'($urandom);
      cycle("rnd");
      if (last_win >= 0) v[last_win] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
